button_bcd_counter: RTL and testbench

Upstream stage of the 4-digit seven-segment display driver. Takes three raw mechanical push-buttons (up, down, clear), synchronises and debounces each, converts accepted presses into single-cycle events, and maintains a 4-digit packed-BCD counter. The 16-bit counter value drives the display's `i_value` input directly, with one hex nibble per digit.

---
 rtl/button_pkg.sv | 60 ++++++
 rtl/button_bcd_counter_debounce.sv | 58 +++++
 rtl/button_bcd_counter.sv | 81 ++++++++
 tb/tb_button_bcd_counter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants, types and packed-BCD helpers
// for the button-driven 4-digit counter.
package button_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  typedef logic [VALUE_W-1:0] bcd_t;

  typedef struct packed {
    logic up;
    logic down;
    logic clr;
  } btn_ev_t;

  // Next packed-BCD value counting up; 9999 wraps to 0000.
  function automatic bcd_t bcd_inc16(input bcd_t v);
    bcd_t r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[i*DIGIT_W +: DIGIT_W] == BCD_MAX) begin
          r[i*DIGIT_W +: DIGIT_W] = BCD_MIN;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] =
            v[i*DIGIT_W +: DIGIT_W] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next packed-BCD value counting down; 0000 wraps to 9999.
  function automatic bcd_t bcd_dec16(input bcd_t v);
    bcd_t r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[i*DIGIT_W +: DIGIT_W] == BCD_MIN) begin
          r[i*DIGIT_W +: DIGIT_W] = BCD_MAX;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] =
            v[i*DIGIT_W +: DIGIT_W] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/button_bcd_counter_debounce.sv
// Per-button 2-flop synchroniser, counting debouncer
// and rising-edge event detect.
module debounce #(
  parameter int DEB_MAX = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_event
);

  localparam int CW = $clog2(DEB_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_MAX - 1);

  logic          meta;
  logic          sync;
  logic          s;
  logic          s_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= i_btn;
      sync <= meta;
    end
  end

  // Accept a new level only after DEB_MAX differing cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s   <= 1'b0;
      cnt <= '0;
    end else if (sync == s) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      s   <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the stable level for edge detect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign o_event = s & ~s_d;

endmodule

// File: rtl/button_bcd_counter.sv
// Three debounced buttons driving a 4-digit
// packed-BCD up/down/clear counter.
module button_bcd_counter
  import button_pkg::*;
#(
  parameter int DEB_MAX = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_btn_up,
  input  logic               i_btn_down,
  input  logic               i_btn_clr,
  output logic [VALUE_W-1:0] o_value,
  output logic               o_press
);

  logic    ev_up;
  logic    ev_down;
  logic    ev_clr;
  btn_ev_t ev;
  logic    do_clr;
  logic    do_inc;
  logic    do_dec;

  debounce #(.DEB_MAX(DEB_MAX)) u_deb_up (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_up),
    .o_event (ev_up)
  );

  debounce #(.DEB_MAX(DEB_MAX)) u_deb_down (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_down),
    .o_event (ev_down)
  );

  debounce #(.DEB_MAX(DEB_MAX)) u_deb_clr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_clr),
    .o_event (ev_clr)
  );

  assign ev.up   = ev_up;
  assign ev.down = ev_down;
  assign ev.clr  = ev_clr;

  // Clear wins; simultaneous up and down cancel out.
  assign do_clr = ev.clr;
  assign do_inc = ev.up & ~ev.down & ~ev.clr;
  assign do_dec = ev.down & ~ev.up & ~ev.clr;

  // BCD register and one-cycle press strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_value <= '0;
      o_press <= 1'b0;
    end else begin
      unique case (1'b1)
        do_clr: begin
          o_value <= '0;
          o_press <= 1'b1;
        end
        do_inc: begin
          o_value <= bcd_inc16(o_value);
          o_press <= 1'b1;
        end
        do_dec: begin
          o_value <= bcd_dec16(o_value);
          o_press <= 1'b1;
        end
        default: begin
          o_press <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_bcd_counter.sv
// Directed and randomized press sequences checked
// against a decimal-integer model of the counter.
module tb_button_bcd_counter;

  localparam int DM = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_btn_up = 1'b0;
  logic        i_btn_down = 1'b0;
  logic        i_btn_clr = 1'b0;
  logic [15:0] o_value;
  logic        o_press;

  int n;
  int passed;
  int total;

  always #5 i_clk = ~i_clk;

  button_bcd_counter #(.DEB_MAX(DM)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_btn_up   (i_btn_up),
    .i_btn_down (i_btn_down),
    .i_btn_clr  (i_btn_clr),
    .o_value    (o_value),
    .o_press    (o_press)
  );

  function automatic logic [15:0] to_bcd(input int v);
    int d;
    d = (v / 1000 % 10) * 4096 + (v / 100 % 10) * 256
      + (v / 10 % 10) * 16 + v % 10;
    return 16'(d);
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Hold the given buttons for h cycles, then release for r cycles.
  task automatic press(input logic u, input logic d,
                       input logic c, input int h,
                       input int r, input bit every);
    int  nn;
    bit  ev;
    bit  pr;
    ev = (h >= DM) && (u || d || c);
    nn = n;
    pr = ev;
    if (ev) begin
      if (c) nn = 0;
      else if (u && d) pr = 0;
      else if (u) nn = (n + 1) % 10000;
      else nn = (n + 9999) % 10000;
    end
    i_btn_up = u;
    i_btn_down = d;
    i_btn_clr = c;
    for (int t = 1; t <= h + r; t++) begin
      @(negedge i_clk);
      if (every || t == h + r) begin
        chk("value", o_value,
            to_bcd((ev && t >= DM + 3) ? nn : n));
        chk("press", {15'd0, o_press},
            {15'd0, (pr && t == DM + 3)});
      end
      if (t == h) begin
        i_btn_up = 1'b0;
        i_btn_down = 1'b0;
        i_btn_clr = 1'b0;
      end
    end
    n = nn;
  endtask

  task automatic ups(input int k);
    for (int i = 0; i < k; i++) press(1, 0, 0, DM, DM + 4, 0);
  endtask

  initial begin
    n = 0;
    passed = 0;
    total = 0;

    for (int i = 0; i < 10; i++) begin
      i_btn_up = 1'($urandom);
      i_btn_down = 1'($urandom);
      i_btn_clr = 1'($urandom);
      @(negedge i_clk);
      chk("rst_value", o_value, 16'h0000);
      chk("rst_press", {15'd0, o_press}, 16'h0000);
    end
    i_btn_up = 1'b0;
    i_btn_down = 1'b0;
    i_btn_clr = 1'b0;
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      chk("idle_value", o_value, 16'h0000);
    end

    for (int i = 0; i < 5; i++) press(1, 0, 0, DM - 1, DM + 4, 1);
    press(1, 0, 0, 20, DM + 4, 1);
    chk("hold_one", o_value, 16'h0001);

    press(0, 0, 1, DM, DM + 4, 1);
    ups(9);
    chk("nine", o_value, 16'h0009);
    press(1, 0, 0, DM, DM + 4, 1);
    chk("ten", o_value, 16'h0010);

    press(0, 0, 1, DM, DM + 4, 1);
    press(0, 1, 0, DM, DM + 4, 1);
    chk("wrap_down", o_value, 16'h9999);
    press(1, 0, 0, DM, DM + 4, 1);
    chk("wrap_up", o_value, 16'h0000);

    ups(5);
    press(1, 1, 0, DM + 2, DM + 4, 1);
    chk("cancel", o_value, 16'h0005);

    press(0, 0, 1, DM, DM + 4, 1);
    ups(42);
    chk("fortytwo", o_value, 16'h0042);
    press(1, 1, 1, DM + 1, DM + 4, 1);
    chk("clr_all", o_value, 16'h0000);

    ups(999);
    chk("preload", o_value, 16'h0999);
    press(1, 0, 0, DM, DM + 4, 1);
    chk("carry3", o_value, 16'h1000);
    press(0, 1, 0, DM, DM + 4, 1);
    chk("borrow3", o_value, 16'h0999);

    press(0, 0, 1, DM, DM + 4, 1);
    ups(123);
    chk("p123", o_value, 16'h0123);
    i_btn_up = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_value", o_value, 16'h0000);
    chk("mid_rst_press", {15'd0, o_press}, 16'h0000);
    n = 0;
    repeat (3) @(negedge i_clk);
    chk("mid_rst_hold", o_value, 16'h0000);
    i_rst_n = 1'b1;
    press(1, 0, 0, 10, DM + 4, 1);
    chk("after_rst", o_value, 16'h0001);

    for (int i = 0; i < 40; i++) begin
      press(1'($urandom), 1'($urandom),
            ($urandom % 5) == 0,
            int'($urandom_range(1, DM + 6)),
            int'($urandom_range(DM + 4, DM + 10)), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
